// File: rtl/branch_history_tracker.sv
// Speculative global-history tracker: forms the PHT read index, carries each
// prediction through Decode/Execute, and repairs history on a mispredict.
module branch_history_tracker #(
  parameter int unsigned HIST_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchF,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  output logic [HIST_W-1:0] PHTinpId,
  input  logic              branchPredictionResult,
  output logic              predictTakenF,
  input  logic              branchE,
  input  logic              branchTakenE,
  output logic              branchPredictedE,
  output logic [HIST_W-1:0] phtIdE,
  output logic              mispredictE,
  output logic [CNT_W-1:0]  branchCount,
  output logic [CNT_W-1:0]  mispredictCount
);

  typedef struct packed {
    logic              valid;
    logic              pred;
    logic [HIST_W-1:0] idx;
  } pipeEntry_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [HIST_W-1:0] specGHR, specGHRNext;
  logic [HIST_W-1:0] archGHR, archGHRNext;
  pipeEntry_t        entryD, entryDNext;
  pipeEntry_t        entryE, entryENext;
  logic [CNT_W-1:0]  branchCountNext, mispredictCountNext;
  logic              fetchAccept;

  // Fetch-side and Execute-side views of the tracked state
  assign PHTinpId         = specGHR;
  assign predictTakenF    = branchF & branchPredictionResult;
  assign branchPredictedE = entryE.pred & entryE.valid;
  assign phtIdE           = entryE.idx;
  // A resolve with no valid prediction in Execute can never count as a mispredict
  assign mispredictE      = branchE & entryE.valid & (branchTakenE != entryE.pred);
  assign fetchAccept      = branchF & ~stallF & ~mispredictE;

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      specGHR         <= '0;
      archGHR         <= '0;
      entryD          <= '0;
      entryE          <= '0;
      branchCount     <= '0;
      mispredictCount <= '0;
    end else begin
      specGHR         <= specGHRNext;
      archGHR         <= archGHRNext;
      entryD          <= entryDNext;
      entryE          <= entryENext;
      branchCount     <= branchCountNext;
      mispredictCount <= mispredictCountNext;
    end
  end

  // Next-state: mispredict beats flush, flush beats stall, stall beats advance
  always_comb begin
    specGHRNext         = specGHR;
    archGHRNext         = archGHR;
    entryDNext          = entryD;
    entryENext          = entryE;
    branchCountNext     = branchCount;
    mispredictCountNext = mispredictCount;

    if (branchE) begin
      archGHRNext = {archGHR[HIST_W-2:0], branchTakenE};
    end

    // Repair uses the committed history plus the outcome being resolved now
    if (mispredictE) begin
      specGHRNext = {archGHR[HIST_W-2:0], branchTakenE};
    end else if (fetchAccept) begin
      specGHRNext = {specGHR[HIST_W-2:0], branchPredictionResult};
    end

    if (mispredictE || flushD) begin
      entryDNext.valid = 1'b0;
    end else if (!stallF && !stallD) begin
      entryDNext.valid = branchF;
      entryDNext.pred  = branchPredictionResult;
      entryDNext.idx   = specGHR;
    end

    if (mispredictE || flushE) begin
      entryENext.valid = 1'b0;
    end else if (!stallD) begin
      entryENext = entryD;
    end

    if (branchE && (branchCount != CntMax)) begin
      branchCountNext = branchCount + CNT_W'(1);
    end
    if (mispredictE && (mispredictCount != CntMax)) begin
      mispredictCountNext = mispredictCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_history_tracker.sv
// Self-checking bench for branch_history_tracker: directed vector table,
// hand-written corner sequences and a randomized run against a reference model.
module tb_branch_history_tracker;

  logic        clk;
  logic        reset;
  logic        branchF, stallF, stallD, flushD, flushE;
  logic [2:0]  PHTinpId;
  logic        branchPredictionResult, predictTakenF;
  logic        branchE, branchTakenE, branchPredictedE;
  logic [2:0]  phtIdE;
  logic        mispredictE;
  logic [15:0] branchCount, mispredictCount;

  int checks   = 0;
  int failures = 0;

  branch_history_tracker #(.HIST_W(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .branchF(branchF), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .PHTinpId(PHTinpId),
    .branchPredictionResult(branchPredictionResult), .predictTakenF(predictTakenF),
    .branchE(branchE), .branchTakenE(branchTakenE), .branchPredictedE(branchPredictedE),
    .phtIdE(phtIdE), .mispredictE(mispredictE), .branchCount(branchCount),
    .mispredictCount(mispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // ins bits: branchF, bpr, stallF, stallD, flushD, flushE, branchE, branchTakenE
  typedef struct {
    bit       rst;
    bit [7:0] ins;
    int       pht, ptf, bpe, idx, chkIdx, mis;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit [7:0] i, input int pht, input int ptf,
                     input int bpe, input int idx, input int ci, input int mis);
    vec_t v;
    v.rst = r; v.ins = i; v.pht = pht; v.ptf = ptf;
    v.bpe = bpe; v.idx = idx; v.chkIdx = ci; v.mis = mis;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit [7:0] i);
    branchF = i[7]; branchPredictionResult = i[6]; stallF = i[5]; stallD = i[4];
    flushD = i[3]; flushE = i[2]; branchE = i[1]; branchTakenE = i[0];
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  // Reference model state: histories as integers, pipeline slots as records
  typedef struct { bit v; bit p; int idx; } slot_t;
  int    mSpec, mArch, mBc, mMc;
  slot_t mD, mE;

  task automatic modelReset();
    mSpec = 0; mArch = 0; mBc = 0; mMc = 0;
    mD = '{0, 0, 0}; mE = '{0, 0, 0};
  endtask

  task automatic modelCheckStep(input int cyc);
    bit    mis;
    slot_t dOld;
    string tag;
    tag = $sformatf("rnd%0d", cyc);
    mis = branchE && mE.v && (branchTakenE != mE.p);
    chk({tag, "_pht"}, int'(PHTinpId), mSpec);
    chk({tag, "_ptf"}, int'(predictTakenF), int'(branchF && branchPredictionResult));
    chk({tag, "_bpe"}, int'(branchPredictedE), int'(mE.v && mE.p));
    chk({tag, "_mis"}, int'(mispredictE), int'(mis));
    if (mE.v) chk({tag, "_idx"}, int'(phtIdE), mE.idx);
    chk({tag, "_bc"}, int'(branchCount), mBc);
    chk({tag, "_mc"}, int'(mispredictCount), mMc);
    dOld = mD;
    if (mis || flushD) mD.v = 0;
    else if (!stallF && !stallD) mD = '{branchF, branchPredictionResult, mSpec};
    if (mis || flushE) mE.v = 0;
    else if (!stallD) mE = dOld;
    if (mis) mSpec = (mArch * 2 + int'(branchTakenE)) % 8;
    else if (branchF && !stallF) mSpec = (mSpec * 2 + int'(branchPredictionResult)) % 8;
    if (branchE) begin
      mArch = (mArch * 2 + int'(branchTakenE)) % 8;
      if (mBc < 65535) mBc++;
      if (mis && mMc < 65535) mMc++;
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(8'b0);
    #12;
    reset = 1'b1;

    // Three predicted-taken fetches from reset
    add(1, 8'b11000000, 0, 1, 0, 0, 1, 0);
    add(0, 8'b11000000, 1, 1, 0, 0, 1, 0);
    add(0, 8'b11000011, 3, 1, 1, 0, 1, 0);
    add(0, 8'b00000011, 7, 0, 1, 1, 1, 0);
    add(0, 8'b00000011, 7, 0, 1, 3, 1, 0);
    // Build archGHR=2, fetch index 2 predicted not-taken, resolve taken
    add(1, 8'b11000011, 0, 1, 0, 0, 1, 0);
    add(0, 8'b10000010, 1, 0, 0, 0, 1, 0);
    add(0, 8'b10000000, 2, 0, 1, 0, 1, 0);
    add(0, 8'b00000000, 4, 0, 0, 1, 1, 0);
    add(0, 8'b00000011, 4, 0, 0, 2, 1, 1);
    add(0, 8'b00000000, 5, 0, 0, 0, 0, 0);
    // Mispredict in the same cycle as a predicted-taken branch fetch
    add(0, 8'b11000000, 5, 1, 0, 0, 0, 0);
    add(0, 8'b11000000, 3, 1, 0, 0, 0, 0);
    add(0, 8'b11000010, 7, 1, 1, 5, 1, 1);
    add(0, 8'b00000000, 2, 0, 0, 0, 0, 0);
    add(0, 8'b00000000, 2, 0, 0, 0, 0, 0);
    // Three-cycle F/D stall with a branch sitting in Decode
    add(0, 8'b11000000, 2, 1, 0, 0, 0, 0);
    add(0, 8'b11110000, 5, 1, 0, 0, 0, 0);
    add(0, 8'b11110000, 5, 1, 0, 0, 0, 0);
    add(0, 8'b11110000, 5, 1, 0, 0, 0, 0);
    add(0, 8'b00000000, 5, 0, 0, 0, 0, 0);
    add(0, 8'b11000000, 5, 1, 1, 2, 1, 0);
    // flushD overriding a stall
    add(0, 8'b00111000, 3, 0, 0, 0, 0, 0);
    add(0, 8'b00000000, 3, 0, 0, 0, 0, 0);
    add(0, 8'b00000000, 3, 0, 0, 0, 0, 0);
    // flushE overriding a stall, then a resolve with nothing valid in Execute
    add(0, 8'b11000000, 3, 1, 0, 0, 0, 0);
    add(0, 8'b00000000, 7, 0, 0, 0, 0, 0);
    add(0, 8'b00110100, 7, 0, 1, 3, 1, 0);
    add(0, 8'b00000011, 7, 0, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      if (vecs[k].rst) pulseReset();
      drive(vecs[k].ins);
      #1;
      chk($sformatf("v%0d_pht", k), int'(PHTinpId), vecs[k].pht);
      chk($sformatf("v%0d_ptf", k), int'(predictTakenF), vecs[k].ptf);
      chk($sformatf("v%0d_bpe", k), int'(branchPredictedE), vecs[k].bpe);
      chk($sformatf("v%0d_mis", k), int'(mispredictE), vecs[k].mis);
      if (vecs[k].chkIdx != 0) chk($sformatf("v%0d_idx", k), int'(phtIdE), vecs[k].idx);
    end
    @(negedge clk);
    drive(8'b0);
    #1;
    chk("table_branchCount", int'(branchCount), 5);
    chk("table_mispredictCount", int'(mispredictCount), 2);

    // Randomized run against the reference model
    pulseReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stallD = ($urandom_range(5) == 0);
      stallF = stallD || ($urandom_range(7) == 0);
      flushD = ($urandom_range(9) == 0);
      flushE = ($urandom_range(9) == 0);
      branchF = ($urandom_range(1) == 1);
      branchPredictionResult = ($urandom_range(1) == 1);
      branchE = mE.v ? ($urandom_range(3) != 0) : ($urandom_range(9) == 0);
      branchTakenE = ($urandom_range(1) == 1);
      #1;
      modelCheckStep(c);
    end

    // Asynchronous reset between edges clears everything before the next edge
    @(negedge clk);
    drive(8'b11000011);
    #2;
    reset = 1'b0;
    #1;
    chk("async_pht", int'(PHTinpId), 0);
    chk("async_bpe", int'(branchPredictedE), 0);
    chk("async_idx", int'(phtIdE), 0);
    chk("async_mis", int'(mispredictE), 0);
    chk("async_bc", int'(branchCount), 0);
    chk("async_mc", int'(mispredictCount), 0);
    reset = 1'b1;

    // Branch counter saturation
    @(negedge clk);
    pulseReset();
    drive(8'b00000010);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", int'(branchCount), 16'hFFFE);
    chk("sat_mc", int'(mispredictCount), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_ffff", int'(branchCount), 16'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", int'(branchCount), 16'hFFFF);
    drive(8'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
